// File: rtl/dp_scheduler.sv
// dp_scheduler: arbitrates a compute requester and a display-refresh scanner
// onto a single datapath. At most one instruction is in flight. A start strobe
// that the datapath never acknowledges is re-issued.

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 12
`endif
`ifndef OPCODE_DISPLAY
`define OPCODE_DISPLAY 4'h2
`endif

module dp_scheduler #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          req_valid,
  input  logic [`INSTRUCTION_WIDTH-1:0] req_instruction,
  output logic                          req_ready,
  output logic                          resp_valid,
  output logic [`RESULT_WIDTH-1:0]      resp_result,
  input  logic                          refresh_en,
  output logic                          frame_done,
  output logic                          dp_start,
  output logic [`INSTRUCTION_WIDTH-1:0] dp_instruction,
  input  logic                          dp_finished,
  input  logic [`RESULT_WIDTH-1:0]      dp_result
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

  state_t                          state_r;
  state_t                          next_state_s;
  logic                            pick_ref_s;      // 1 = refresh wins this grant
  logic                            issue_s;         // IDLE -> ISSUE this cycle
  logic                            done_s;          // WAIT_DONE -> RESPOND this cycle
  logic                            last_pixel_s;
  logic                            grant_ref_r;     // source of the op in flight
  logic                            last_grant_ref_r;
  logic [1:0]                      retry_cnt_r;
  logic [7:0]                      x_r;
  logic [6:0]                      y_r;
  logic                            dp_start_r;
  logic                            req_ready_r;
  logic                            resp_valid_r;
  logic                            frame_done_r;
  logic [`RESULT_WIDTH-1:0]        resp_result_r;
  logic [`INSTRUCTION_WIDTH-1:0]   dp_instruction_r;

  // Build the DISPLAY instruction for scanner position (px, py).
  function automatic logic [`INSTRUCTION_WIDTH-1:0] display_instr(
    input logic [7:0] px,
    input logic [6:0] py
  );
    logic [`INSTRUCTION_WIDTH-1:0] instr_v;
    instr_v = {`INSTRUCTION_WIDTH{1'b0}};
    instr_v[`OPCODE_WIDTH-1:0] = `OPCODE_DISPLAY;
    instr_v[11:4]  = px;
    instr_v[18:12] = py;
    return instr_v;
  endfunction

  assign issue_s      = (state_r == IDLE) && (next_state_s == ISSUE);
  assign done_s       = (state_r == WAIT_DONE) && (next_state_s == RESPOND);
  assign last_pixel_s = (x_r == X_LAST) && (y_r == Y_LAST);

  // Next-state logic and round-robin source selection.
  always_comb begin
    next_state_s = state_r;
    pick_ref_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (dp_finished && (req_valid || refresh_en)) begin
          next_state_s = ISSUE;
          if (req_valid && refresh_en) begin
            // Tie: the source not granted last time wins.
            pick_ref_s = ~last_grant_ref_r;
          end else begin
            pick_ref_s = refresh_en;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        next_state_s = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!dp_finished) begin
          next_state_s = WAIT_DONE;
        end else if (retry_cnt_r == 2'd3) begin
          // Datapath never went busy over four cycles: strobe again.
          next_state_s = ISSUE;
        end else begin
          next_state_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (dp_finished) begin
          next_state_s = RESPOND;
        end else begin
          next_state_s = WAIT_DONE;
        end
      end
      RESPOND: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and single-cycle strobes, all registered from next state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r      <= IDLE;
      dp_start_r   <= 1'b0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      dp_start_r   <= (next_state_s == ISSUE);
      req_ready_r  <= issue_s && !pick_ref_s;
      resp_valid_r <= done_s && !grant_ref_r;
      frame_done_r <= done_s && grant_ref_r && last_pixel_s;
    end
  end

  // Grant bookkeeping and instruction latch, updated on acceptance only.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      grant_ref_r      <= 1'b0;
      last_grant_ref_r <= 1'b1;
      dp_instruction_r <= {`INSTRUCTION_WIDTH{1'b0}};
    end else if (issue_s) begin
      grant_ref_r      <= pick_ref_s;
      last_grant_ref_r <= pick_ref_s;
      dp_instruction_r <= pick_ref_s ? display_instr(x_r, y_r) : req_instruction;
    end
  end

  // Counts cycles the datapath stays idle after a strobe.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      retry_cnt_r <= 2'd0;
    end else if ((state_r == WAIT_BUSY) && dp_finished) begin
      retry_cnt_r <= retry_cnt_r + 2'd1;
    end else begin
      retry_cnt_r <= 2'd0;
    end
  end

  // Compute result capture; held until the next compute completion.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      resp_result_r <= {`RESULT_WIDTH{1'b0}};
    end else if (done_s && !grant_ref_r) begin
      resp_result_r <= dp_result;
    end
  end

  // Scanner position advances only when a DISPLAY op completes.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_r <= 8'd0;
      y_r <= 7'd0;
    end else if (done_s && grant_ref_r) begin
      if (x_r == X_LAST) begin
        x_r <= 8'd0;
        if (y_r == Y_LAST) begin
          y_r <= 7'd0;
        end else begin
          y_r <= y_r + 7'd1;
        end
      end else begin
        x_r <= x_r + 8'd1;
      end
    end
  end

  assign dp_start       = dp_start_r;
  assign dp_instruction = dp_instruction_r;
  assign req_ready      = req_ready_r;
  assign resp_valid     = resp_valid_r;
  assign resp_result    = resp_result_r;
  assign frame_done     = frame_done_r;

endmodule

// File: tb/tb_dp_scheduler.sv
// Self-checking bench for dp_scheduler with a small behavioural datapath.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 12
`endif
`ifndef OPCODE_DISPLAY
`define OPCODE_DISPLAY 4'h2
`endif

module tb_dp_scheduler;

  localparam logic [3:0] OP_MEMREAD = 4'h1;

  logic                          clock = 1'b0;
  logic                          resetn = 1'b0;
  logic                          req_valid = 1'b0;
  logic [`INSTRUCTION_WIDTH-1:0] req_instruction = '0;
  logic                          req_ready;
  logic                          resp_valid;
  logic [`RESULT_WIDTH-1:0]      resp_result;
  logic                          refresh_en = 1'b0;
  logic                          frame_done;
  logic                          dp_start;
  logic [`INSTRUCTION_WIDTH-1:0] dp_instruction;
  logic                          dp_finished;
  logic [`RESULT_WIDTH-1:0]      dp_result;

  int tests_run = 0;
  int tests_failed = 0;

  // datapath model controls (driven by the test sequence)
  int busy_len = 2;
  int ignore_base = 0;
  int drop_starts = 0;

  // datapath model state
  int                            busy_cnt = 0;
  int                            starts_total = 0;
  logic [`INSTRUCTION_WIDTH-1:0] lat_instr = '0;
  logic [`INSTRUCTION_WIDTH-1:0] start_log[$];

  logic [`RESULT_WIDTH-1:0] exp_q[$];

  dp_scheduler #(.SCREEN_W(4), .SCREEN_H(2)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_instruction(req_instruction), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_result(resp_result),
    .refresh_en(refresh_en), .frame_done(frame_done),
    .dp_start(dp_start), .dp_instruction(dp_instruction),
    .dp_finished(dp_finished), .dp_result(dp_result)
  );

  always #5 clock = ~clock;

  function automatic logic [`RESULT_WIDTH-1:0] dp_model(input logic [`INSTRUCTION_WIDTH-1:0] ins);
    logic [11:0] addr;
    addr = {4'h0, ins[11:4]};
    if (ins[3:0] == OP_MEMREAD) return 12'h0A6 + addr;
    return 12'hFFF;
  endfunction

  function automatic logic [`INSTRUCTION_WIDTH-1:0] mk_memread(input int addr);
    logic [`INSTRUCTION_WIDTH-1:0] v;
    v = '0;
    v[3:0]  = OP_MEMREAD;
    v[11:4] = 8'(addr);
    return v;
  endfunction

  function automatic logic [`INSTRUCTION_WIDTH-1:0] mk_pix(input int px, input int py);
    logic [`INSTRUCTION_WIDTH-1:0] v;
    v = '0;
    v[3:0]   = `OPCODE_DISPLAY;
    v[11:4]  = 8'(px);
    v[18:12] = 7'(py);
    return v;
  endfunction

  // Behavioural datapath: busy for busy_len cycles after an accepted start.
  always @(posedge clock) begin
    if (!resetn) begin
      dp_finished <= 1'b1;
      dp_result   <= 12'h000;
      busy_cnt    <= 0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        dp_finished <= 1'b1;
        dp_result   <= dp_model(lat_instr);
      end
    end else if (dp_start) begin
      starts_total <= starts_total + 1;
      start_log.push_back(dp_instruction);
      if (!((starts_total - ignore_base) < drop_starts)) begin
        dp_finished <= 1'b0;
        busy_cnt    <= busy_len;
        lat_instr   <= dp_instruction;
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    req_valid = 1'b0;
    refresh_en = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({dp_start, req_ready, resp_valid, frame_done} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b expected 0000", {dp_start, req_ready, resp_valid, frame_done});
    end
    tests_run++;
    if (resp_result !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_result: got %h expected 000", resp_result);
    end
    tests_run++;
    if (dp_instruction !== '0) begin
      tests_failed++;
      $display("FAIL reset_instr: got %h expected 0", dp_instruction);
    end
    resetn = 1'b1;
  endtask

  task automatic test_single_compute();
    int ready_cnt = 0, resp_cnt = 0, base, extra = 0;
    logic [`RESULT_WIDTH-1:0] e;
    busy_len = 3;
    base = starts_total;
    exp_q.push_back(12'h0AB);
    req_instruction = mk_memread(5);
    req_valid = 1'b1;
    for (int c = 0; c < 60 && resp_cnt == 0; c++) begin
      @(negedge clock);
      if (req_ready) begin ready_cnt++; req_valid = 1'b0; end
      if (resp_valid) begin
        resp_cnt++;
        e = exp_q.pop_front();
        tests_run++;
        if (resp_result !== e) begin
          tests_failed++;
          $display("FAIL single_result: got %h expected %h", resp_result, e);
        end
      end
    end
    tests_run++;
    if (resp_cnt != 1) begin tests_failed++; $display("FAIL single_resp_count: got %0d expected 1", resp_cnt); end
    tests_run++;
    if (ready_cnt != 1) begin tests_failed++; $display("FAIL single_ready_count: got %0d expected 1", ready_cnt); end
    tests_run++;
    if (starts_total - base != 1) begin tests_failed++; $display("FAIL single_starts: got %0d expected 1", starts_total - base); end
    tests_run++;
    if (start_log[base] !== mk_memread(5)) begin tests_failed++; $display("FAIL single_dp_instr: got %h expected %h", start_log[base], mk_memread(5)); end
    repeat (6) begin
      @(negedge clock);
      if (resp_valid) extra++;
    end
    tests_run++;
    if (extra != 0 || resp_result !== 12'h0AB) begin
      tests_failed++;
      $display("FAIL single_hold: extra pulses %0d result %h expected 0 and 0ab", extra, resp_result);
    end
  endtask

  task automatic test_contention();
    int base;
    logic [`RESULT_WIDTH-1:0] e;
    do_reset();
    busy_len = 2;
    base = starts_total;
    req_instruction = mk_memread(9);
    req_valid = 1'b1;
    refresh_en = 1'b1;
    for (int c = 0; c < 300 && start_log.size() < base + 6; c++) begin
      @(negedge clock);
      if (req_ready) exp_q.push_back(12'h0AF);
      if (resp_valid) begin
        e = exp_q.pop_front();
        tests_run++;
        if (resp_result !== e) begin tests_failed++; $display("FAIL contention_result: got %h expected %h", resp_result, e); end
      end
    end
    req_valid = 1'b0;
    refresh_en = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (req_ready) exp_q.push_back(12'h0AF);
      if (resp_valid) begin
        e = exp_q.pop_front();
        tests_run++;
        if (resp_result !== e) begin tests_failed++; $display("FAIL contention_result: got %h expected %h", resp_result, e); end
      end
    end
    for (int i = 0; i < 6; i++) begin
      logic [`INSTRUCTION_WIDTH-1:0] want;
      want = (i % 2 == 0) ? mk_memread(9) : mk_pix(i / 2, 0);
      tests_run++;
      if (start_log[base + i] !== want) begin
        tests_failed++;
        $display("FAIL contention_grant%0d: got %h expected %h", i, start_log[base + i], want);
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL contention_pending: got %0d expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_scan_wrap();
    int base, frame_cnt = 0, frame_at = -1;
    do_reset();
    busy_len = 1;
    base = starts_total;
    refresh_en = 1'b1;
    for (int c = 0; c < 300 && start_log.size() < base + 9; c++) begin
      @(negedge clock);
      if (frame_done) begin frame_cnt++; frame_at = start_log.size() - base; end
    end
    refresh_en = 1'b0;
    repeat (15) begin
      @(negedge clock);
      if (frame_done) begin frame_cnt++; frame_at = start_log.size() - base; end
    end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (start_log[base + i] !== mk_pix(i % 4, (i / 4) % 2)) begin
        tests_failed++;
        $display("FAIL scan_pixel%0d: got %h expected %h", i, start_log[base + i], mk_pix(i % 4, (i / 4) % 2));
      end
    end
    tests_run++;
    if (frame_cnt != 1) begin tests_failed++; $display("FAIL scan_frame_count: got %0d expected 1", frame_cnt); end
    tests_run++;
    if (frame_at != 8) begin tests_failed++; $display("FAIL scan_frame_pos: got %0d expected 8", frame_at); end
  endtask

  task automatic test_missed_start();
    int base, resp_cnt = 0, first_c = -1, second_c = -1;
    logic [`RESULT_WIDTH-1:0] e;
    do_reset();
    busy_len = 2;
    ignore_base = starts_total;
    drop_starts = 1;
    base = starts_total;
    exp_q.push_back(12'h0A9);
    req_instruction = mk_memread(3);
    req_valid = 1'b1;
    for (int c = 0; c < 80 && resp_cnt == 0; c++) begin
      @(negedge clock);
      if (req_ready) req_valid = 1'b0;
      if (dp_start) begin
        if (first_c < 0) first_c = c; else if (second_c < 0) second_c = c;
      end
      if (resp_valid) begin
        resp_cnt++;
        e = exp_q.pop_front();
        tests_run++;
        if (resp_result !== e) begin tests_failed++; $display("FAIL missed_result: got %h expected %h", resp_result, e); end
      end
    end
    repeat (6) begin
      @(negedge clock);
      if (resp_valid) resp_cnt++;
    end
    drop_starts = 0;
    tests_run++;
    if (second_c - first_c != 5 || first_c < 0) begin
      tests_failed++;
      $display("FAIL missed_gap: got %0d expected 5", second_c - first_c);
    end
    tests_run++;
    if (starts_total - base != 2) begin tests_failed++; $display("FAIL missed_starts: got %0d expected 2", starts_total - base); end
    tests_run++;
    if (resp_cnt != 1) begin tests_failed++; $display("FAIL missed_resp_count: got %0d expected 1", resp_cnt); end
  endtask

  task automatic test_reset_mid();
    int base, resp_cnt = 0, seen_ready = 0;
    do_reset();
    busy_len = 1;
    base = starts_total;
    refresh_en = 1'b1;
    for (int c = 0; c < 100 && start_log.size() < base + 3; c++) @(negedge clock);
    refresh_en = 1'b0;
    repeat (10) @(negedge clock);
    busy_len = 8;
    req_instruction = mk_memread(7);
    req_valid = 1'b1;
    for (int c = 0; c < 20 && seen_ready == 0; c++) begin
      @(negedge clock);
      if (req_ready) begin seen_ready = 1; req_valid = 1'b0; end
    end
    repeat (4) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({dp_start, req_ready, resp_valid, frame_done, resp_result, dp_instruction} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %b%b%b%b %h %h expected all zero",
               dp_start, req_ready, resp_valid, frame_done, resp_result, dp_instruction);
    end
    resetn = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (resp_valid) resp_cnt++;
    end
    tests_run++;
    if (resp_cnt != 0) begin tests_failed++; $display("FAIL midreset_no_resp: got %0d expected 0", resp_cnt); end
    base = start_log.size();
    refresh_en = 1'b1;
    for (int c = 0; c < 40 && start_log.size() < base + 1; c++) @(negedge clock);
    refresh_en = 1'b0;
    tests_run++;
    if (start_log[base] !== mk_pix(0, 0)) begin
      tests_failed++;
      $display("FAIL midreset_scan_restart: got %h expected %h", start_log[base], mk_pix(0, 0));
    end
    repeat (10) @(negedge clock);
  endtask

  task automatic test_refresh_toggle();
    int base, held;
    do_reset();
    busy_len = 1;
    base = starts_total;
    refresh_en = 1'b1;
    for (int c = 0; c < 200 && start_log.size() < base + 7; c++) @(negedge clock);
    refresh_en = 1'b0;
    repeat (20) @(negedge clock);
    held = start_log.size() - base;
    tests_run++;
    if (held != 7) begin tests_failed++; $display("FAIL toggle_hold: got %0d starts expected 7", held); end
    refresh_en = 1'b1;
    for (int c = 0; c < 40 && start_log.size() < base + 8; c++) @(negedge clock);
    refresh_en = 1'b0;
    tests_run++;
    if (start_log[base + 6] !== mk_pix(2, 1)) begin
      tests_failed++;
      $display("FAIL toggle_before: got %h expected %h", start_log[base + 6], mk_pix(2, 1));
    end
    tests_run++;
    if (start_log[base + 7] !== mk_pix(3, 1)) begin
      tests_failed++;
      $display("FAIL toggle_resume: got %h expected %h", start_log[base + 7], mk_pix(3, 1));
    end
    repeat (10) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single_compute();
    test_contention();
    test_scan_wrap();
    test_missed_start();
    test_reset_mid();
    test_refresh_toggle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
